// File: rtl/shiftreg_ctrl_pkg.sv
// Shared types and parameter limits for the shift-register sequencing controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package shiftreg_ctrl_pkg;

    // Controller phases: waiting for a word, serializing bits, final latch period.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_LATCH = 2'd2
    } state_t;

    // Smallest legal parameter values; below these the timing scheme breaks down.
    localparam int MIN_DIVIDE = 2;
    localparam int MIN_WIDTH  = 1;

endpackage

// File: rtl/shiftreg_ctrl_tick_gen.sv
// Bit-period divider: counts 0..DIVIDE-1 and flags the wrap cycle on tick.
// Latency: tick is combinational from the count register; clear takes effect next edge.
// Backpressure: none; clr holds the count at zero and suppresses tick.
module tick_gen #(
    parameter int DIVIDE = 5
) (
    input  logic sysclk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int                CW   = $clog2(DIVIDE);
    localparam logic [CW-1:0]     LAST = CW'(DIVIDE - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: held at zero while cleared, otherwise wraps at DIVIDE-1.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (cnt_q == LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge sysclk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = !clr && (cnt_q == LAST);

endmodule

// File: rtl/shiftreg_ctrl.sv
// Serializes a parallel word into an external shift register using shift_en strobes, then pulses latch.
// Latency: k-th shift_en at N+k*DIVIDE after acceptance at N, latch at N+(WIDTH+1)*DIVIDE; all outputs registered.
// Backpressure: load_ready is low from the cycle after acceptance through the latch cycle. Build option: SHIFTREG_CTRL_LSB_FIRST_EN.
module shiftreg_ctrl
    import shiftreg_ctrl_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int DIVIDE = 5
) (
    input  logic             sysclk,
    input  logic             rst,
    input  logic [WIDTH-1:0] load_data,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             shift_en,
    output logic             databit,
    output logic             latch,
    output logic             busy
);

    localparam int            BW       = $clog2(WIDTH + 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

    // Elaboration-time guard against parameter values the timing cannot support.
    if (WIDTH < MIN_WIDTH) begin : g_bad_width
        $error("shiftreg_ctrl: WIDTH must be at least 1");
    end
    if (DIVIDE < MIN_DIVIDE) begin : g_bad_divide
        $error("shiftreg_ctrl: DIVIDE must be at least 2");
    end

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shadow_q, shadow_d;
    logic [BW-1:0]    bitcnt_q, bitcnt_d;
    logic             load_ready_q, load_ready_d;
    logic             shift_en_q, shift_en_d;
    logic             databit_q, databit_d;
    logic             latch_q, latch_d;
    logic             busy_q, busy_d;

    logic accept;
    logic div_clr;
    logic tick;

    // The divider is held at zero while idle and starts counting in the acceptance
    // cycle, so its first wrap lands one cycle before the first registered strobe.
    tick_gen #(
        .DIVIDE (DIVIDE)
    ) u_tick_gen (
        .sysclk (sysclk),
        .rst    (rst),
        .clr    (div_clr),
        .tick   (tick)
    );

    assign accept = (state_q == ST_IDLE) && load_valid && load_ready_q;

    // Next-state and registered-output decode for the IDLE/SHIFT/LATCH sequence.
    always_comb begin
        state_d      = state_q;
        shadow_d     = shadow_q;
        bitcnt_d     = bitcnt_q;
        load_ready_d = load_ready_q;
        shift_en_d   = 1'b0;
        databit_d    = databit_q;
        latch_d      = 1'b0;
        busy_d       = busy_q;
        div_clr      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Also covers the latch cycle (already back in IDLE with ready low),
                // so ready rises exactly one cycle after latch.
                div_clr      = !accept;
                bitcnt_d     = '0;
                load_ready_d = !accept;
                busy_d       = accept;
                if (accept) begin
                    shadow_d = load_data;
                    state_d  = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (tick) begin
                    shift_en_d = 1'b1;
                    bitcnt_d   = bitcnt_q + 1'b1;
`ifdef SHIFTREG_CTRL_LSB_FIRST_EN
                    databit_d  = shadow_q[0];
                    shadow_d   = shadow_q >> 1;
`else
                    databit_d  = shadow_q[WIDTH-1];
                    shadow_d   = shadow_q << 1;
`endif
                    if (bitcnt_q == LAST_BIT) begin
                        state_d = ST_LATCH;
                    end
                end
            end
            ST_LATCH: begin
                if (tick) begin
                    latch_d = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, datapath and output registers; reset aborts any transfer outright.
    always_ff @(posedge sysclk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            shadow_q     <= '0;
            bitcnt_q     <= '0;
            load_ready_q <= 1'b0;
            shift_en_q   <= 1'b0;
            databit_q    <= 1'b0;
            latch_q      <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            shadow_q     <= shadow_d;
            bitcnt_q     <= bitcnt_d;
            load_ready_q <= load_ready_d;
            shift_en_q   <= shift_en_d;
            databit_q    <= databit_d;
            latch_q      <= latch_d;
            busy_q       <= busy_d;
        end
    end

    assign load_ready = load_ready_q;
    assign shift_en   = shift_en_q;
    assign databit    = databit_q;
    assign latch      = latch_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_shiftreg_ctrl.sv
// Bench for shiftreg_ctrl: directed and random words against a cycle-timing model,
// plus a WIDTH=1/DIVIDE=2 instance with fixed expectations.
// Works in both the default and the LSB-first build.
module tb_shiftreg_ctrl;

    localparam int W = 4;
    localparam int D = 5;

    logic         sysclk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] load_data = '0;
    logic         load_valid = 1'b0;
    logic         load_ready, shift_en, databit, latch, busy;

    logic         e_rst = 1'b1;
    logic [0:0]   e_data = 1'b0;
    logic         e_valid = 1'b0;
    logic         e_ready, e_shift_en, e_databit, e_latch, e_busy;

    always #5 sysclk = ~sysclk;

    shiftreg_ctrl #(.WIDTH(W), .DIVIDE(D)) u_dut (
        .sysclk     (sysclk),
        .rst        (rst),
        .load_data  (load_data),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .shift_en   (shift_en),
        .databit    (databit),
        .latch      (latch),
        .busy       (busy)
    );

    shiftreg_ctrl #(.WIDTH(1), .DIVIDE(2)) u_dut_edge (
        .sysclk     (sysclk),
        .rst        (e_rst),
        .load_data  (e_data),
        .load_valid (e_valid),
        .load_ready (e_ready),
        .shift_en   (e_shift_en),
        .databit    (e_databit),
        .latch      (e_latch),
        .busy       (e_busy)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Reference model: the last reset cycle and the last accepted word with its cycle.
    int           last_rst = 0;
    bit           active   = 1'b0;
    int           acc_c    = 0;
    logic [W-1:0] word     = '0;
    logic         db_exp   = 1'b0;
    bit           accepted = 1'b0;

    function automatic bit m_busy(int c);
        int d;
        d = c - acc_c;
        return active && (d >= 1) && (d <= (W + 1) * D);
    endfunction

    function automatic bit m_ready(int c);
        return (c >= last_rst + 2) && !m_busy(c);
    endfunction

    task automatic check1(input string tag, input logic obs, input logic expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s cyc=%0d got=%b exp=%b", tag, cyc, obs, expv);
        end
    endtask

    task automatic check_cycle();
        int   d;
        int   k;
        logic e_se, e_la;
        d    = cyc - acc_c;
        k    = d / D;
        e_se = active && (d > 0) && ((d % D) == 0) && (k <= W);
        e_la = active && (d == (W + 1) * D);
        if (e_se) begin
`ifdef SHIFTREG_CTRL_LSB_FIRST_EN
            db_exp = word[k - 1];
`else
            db_exp = word[W - k];
`endif
        end
        if (cyc == last_rst + 1) db_exp = 1'b0;
        check1("shift_en",   shift_en,   e_se);
        check1("latch",      latch,      e_la);
        check1("busy",       busy,       m_busy(cyc));
        check1("load_ready", load_ready, m_ready(cyc));
        check1("databit",    databit,    db_exp);
    endtask

    // Drive one cycle of inputs, advance the model, then check the next cycle's outputs.
    task automatic step(input logic r, input logic v, input logic [W-1:0] dat);
        rst        = r;
        load_valid = v;
        load_data  = dat;
        accepted   = 1'b0;
        if (r) begin
            last_rst = cyc;
            active   = 1'b0;
        end else if (v && m_ready(cyc)) begin
            active   = 1'b1;
            acc_c    = cyc;
            word     = dat;
            accepted = 1'b1;
        end
        @(negedge sysclk);
        cyc++;
        check_cycle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int           n;
        bit           pend;
        logic [W-1:0] req;
        logic [W-1:0] first_word;

        // Reset, then idle; first word at cycle 10.
        step(1'b1, 1'b0, '0);
        repeat (9) step(1'b0, 1'b0, '0);
        first_word = 4'b1011;
        step(1'b0, 1'b1, first_word);

        // Back-to-back: valid held through the first transfer, then 4'hF, then 4'h0.
        n = 0;
        do begin step(1'b0, 1'b1, 4'hF); n++; end while (!accepted && n < 60);
        check1("b2b_first_accept", accepted, 1'b1);
        n = 0;
        do begin step(1'b0, 1'b1, 4'h0); n++; end while (!accepted && n < 60);
        check1("b2b_second_accept", accepted, 1'b1);
        repeat (30) step(1'b0, 1'b0, '0);

        // Reset twelve cycles into a transfer, then a fresh word.
        step(1'b0, 1'b1, 4'b1101);
        repeat (11) step(1'b0, 1'b0, '0);
        step(1'b1, 1'b0, '0);
        repeat (3) step(1'b0, 1'b0, '0);
        n = 0;
        do begin step(1'b0, 1'b1, 4'b1001); n++; end while (!accepted && n < 60);
        repeat (30) step(1'b0, 1'b0, '0);

        // Reset and valid together: reset wins, nothing shifts afterwards.
        step(1'b1, 1'b1, 4'hA);
        repeat (30) step(1'b0, 1'b0, '0);

        // Random traffic with hold-until-accepted requests and rare resets.
        pend = 1'b0;
        req  = '0;
        for (int i = 0; i < 600; i++) begin
            if (!pend && ($urandom_range(0, 2) == 0)) begin
                pend = 1'b1;
                req  = W'($urandom);
            end
            step(($urandom_range(0, 99) == 0), pend, req);
            if (accepted) pend = 1'b0;
        end
        repeat (30) step(1'b0, 1'b0, '0);

        // Edge parameters WIDTH=1, DIVIDE=2.
        e_rst = 1'b1;
        @(negedge sysclk);
        e_rst = 1'b0;
        check1("edge_reset_ready", e_ready, 1'b0);
        check1("edge_reset_busy", e_busy, 1'b0);
        @(negedge sysclk);
        check1("edge_ready_idle", e_ready, 1'b1);
        e_valid = 1'b1;
        e_data  = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            @(negedge sysclk);
            e_valid = 1'b0;
            check1("edge_shift_en", e_shift_en, (i == 2));
            check1("edge_latch",    e_latch,    (i == 4));
            check1("edge_busy",     e_busy,     (i >= 1 && i <= 4));
            check1("edge_ready",    e_ready,    (i >= 5));
            check1("edge_databit",  e_databit,  (i >= 2));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/shiftreg_ctrl.md
# shiftreg_ctrl

Sequencing controller for the board's serial-in shift register (WIDTH-bit, driven by `clk`/`databit`/`rst`, parallel outputs to the LEDs). It accepts a parallel word over a valid/ready handshake, serializes it one bit per divided tick using a clock-enable strobe, and then issues a latch pulse. It sits between the `sysclk`-domain pattern logic (counters, pattern generators) and the shift-register instance, replacing ad-hoc divided clocks with a single-clock enable scheme.

## Interface
- `WIDTH`, default 4: shift-register length in bits; legal range 1 or more.
- `DIVIDE`, default 5: `sysclk` cycles per bit period; legal range 2 or more.
- Clock and reset: one clock; reset is synchronous and active-high.
- `sysclk`, input, 1: system clock; all logic is on its rising edge.
- `rst`, input, 1: synchronous active-high reset.
- `load_data`, input, WIDTH: word to serialize.
- `load_valid`, input, 1: `load_data` is valid.
- `load_ready`, output, 1: controller is idle and can accept a word.
- `shift_en`, output, 1: one-cycle strobe; the shift register captures `databit` on this cycle.
- `databit`, output, 1: serial data, valid whenever `shift_en` is high.
- `latch`, output, 1: one-cycle strobe after the last bit; transfers the shift contents to the outputs.
- `busy`, output, 1: high in SHIFT and LATCH.

## Operation
- All outputs are registered.
- Reset values: `load_ready`=0, `shift_en`=0, `databit`=0, `latch`=0, `busy`=0. The state goes to IDLE and the shadow register, divider and bit counter are cleared.
- FSM states are IDLE, SHIFT and LATCH.
- IDLE:
  - `load_ready`=1, starting from the first cycle after `rst` deasserts.
  - Acceptance happens when `load_valid && load_ready`.
  - On acceptance: capture `load_data` into the shadow register, clear the divider and bit counter, go to SHIFT, and drop `load_ready` on the next cycle.
- SHIFT:
  - The divider counts 0..DIVIDE-1 and wraps.
  - On each wrap, for the following cycle: assert `shift_en`, drive `databit` with the next bit, shift the shadow register, and increment the bit counter.
  - Bit order is MSB first.
  - After the WIDTH-th strobe, go to LATCH.
- LATCH: one more divider period elapses, then `latch` is asserted for one cycle, and the FSM returns to IDLE.
- `databit` holds its last value outside strobe cycles; consumers must ignore it then.
- `load_valid` while not ready is ignored. The requester must hold `load_valid` and `load_data` until acceptance.
- `rst` asserted mid-transfer aborts the transfer immediately: outputs take reset values on the next edge, and no partial `latch` is issued.
- `rst` has priority over every other event, including acceptance in the same cycle.
- Counter widths: divider is `$clog2(DIVIDE)`; bit counter is `$clog2(WIDTH+1)`. Neither may overflow for any legal parameter value.

## Timing
- Acceptance occurs at cycle N.
- The k-th `shift_en` (k=1..WIDTH) is at cycle N + k·DIVIDE.
- `latch` is at cycle N + (WIDTH+1)·DIVIDE.
- `busy` is high from N+1 through the `latch` cycle inclusive.
- `load_ready` returns to 1 at the cycle after `latch`. A new word may be accepted in that cycle.
- Minimum word-to-word period is (WIDTH+1)·DIVIDE + 1 cycles.
- `shift_en` and `latch` are never high in the same cycle, and never high for two consecutive cycles.

## Configuration
- `SHIFTREG_CTRL_LSB_FIRST_EN`:
  - Defined: bits are serialized LSB first (the shadow register shifts right, `databit` = bit 0).
  - Undefined (default): MSB first.
- Timing is identical in both builds.

## Structure
- `shiftreg_ctrl_pkg` holds:
  - the FSM state typedef (IDLE/SHIFT/LATCH, 2-bit encoding);
  - parameter-check constants (minimum DIVIDE = 2, minimum WIDTH = 1).
- Sub-module `tick_gen` (parameter DIVIDE) is the divider. Its ports are `sysclk`, `rst`, a synchronous clear and a `tick` output, where `tick` is high on the wrap cycle.
- The FSM, shadow register and bit counter live in `shiftreg_ctrl`.

## Test plan
Unless noted, WIDTH=4 and DIVIDE=5.
- Basic MSB-first: `load_data`=4'b1011 accepted at cycle 10 → `shift_en` at 15/20/25/30 with `databit` 1,0,1,1; `latch` at 35; `load_ready`=1 at 36.
- LSB-first build (`SHIFTREG_CTRL_LSB_FIRST_EN`), same stimulus → `databit` 1,1,0,1 at the same cycles.
- Back-to-back: `load_valid` held high with 4'hF then 4'h0 → second acceptance at cycle 36; its first `shift_en` at 41; `load_ready` low throughout both transfers.
- Reset mid-transfer: `rst` pulsed at cycle 22 → at cycle 23 all outputs are 0; no `latch` follows; `load_ready`=1 the cycle after `rst` falls; a new word shifts normally.
- Reset priority: `rst` and `load_valid` both high in the same cycle → no acceptance, and no `shift_en` within the next 30 cycles.
- Edge parameters: WIDTH=1, DIVIDE=2, data 1'b1 accepted at N → `shift_en` at N+2 with `databit`=1, `latch` at N+4, `load_ready` at N+5.
